i2c_slave: RTL and testbench

- I2C target (responder) for the on-chip I2C master: decodes START/STOP, matches a 7-bit address, ACKs, accepts write bytes into a 4-byte register bank, and returns bank bytes on reads.
- Runs on the system clock and oversamples SCL/SDA; it does not stretch the clock.
- Sits on the same SCL/SDA pair as the master, so the master/slave pair can be looped back on one board.

---
 rtl/i2c_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled START/STOP decode, 7-bit address match, write
// bytes into a small register bank, read bytes back out. No clock stretching.
module i2c_slave #(
  parameter logic [6:0]  SLV_ADDR = 7'h5A,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  logic                  SDA,
  output logic [8*NUM_REGS-1:0] slv_regs,
  output logic [7:0]            rx_data,
  output logic                  rx_done,
  output logic                  addr_match,
  output logic                  busy
);

  localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       tx_shift, tx_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             rw, rw_nxt;
  logic             ack_bit, ack_nxt;
  logic             sda_oe, sda_oe_nxt;
  logic [8*NUM_REGS-1:0] regs_nxt;
  logic [7:0]       rx_data_nxt;
  logic             rx_done_nxt, am_nxt, busy_nxt;
  logic [PTR_W-1:0] ptr_inc;
  logic [7:0]       cur_byte;

  // Open-drain pad: only ever pull low or release.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;

  assign ptr_inc  = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign cur_byte = slv_regs[{ptr, 3'b000} +: 8];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_shift   <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      ack_bit    <= 1'b1;
      sda_oe     <= 1'b0;
      slv_regs   <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      tx_shift   <= tx_nxt;
      ptr        <= ptr_nxt;
      rw         <= rw_nxt;
      ack_bit    <= ack_nxt;
      sda_oe     <= sda_oe_nxt;
      slv_regs   <= regs_nxt;
      rx_data    <= rx_data_nxt;
      rx_done    <= rx_done_nxt;
      addr_match <= am_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and datapath: STOP beats START beats the protocol FSM.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    tx_nxt      = tx_shift;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    ack_nxt     = ack_bit;
    sda_oe_nxt  = sda_oe;
    regs_nxt    = slv_regs;
    rx_data_nxt = rx_data;
    rx_done_nxt = 1'b0;
    am_nxt      = addr_match;
    busy_nxt    = busy;

    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      am_nxt     = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      ptr_nxt     = '0;
      busy_nxt    = 1'b1;
      am_nxt      = 1'b0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_nxt = 1'b0;
        end

        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_s2};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == SLV_ADDR) begin
              sda_oe_nxt = 1'b1;
              am_nxt     = 1'b1;
              rw_nxt     = shift[0];
              state_nxt  = ADDR_ACK;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              tx_nxt      = cur_byte;
              sda_oe_nxt  = ~cur_byte[7];
              bit_cnt_nxt = 4'd1;
              state_nxt   = READ;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = WRITE;
            end
          end
        end

        WRITE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_s2};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            regs_nxt[{ptr, 3'b000} +: 8] = shift;
            rx_data_nxt = shift;
            rx_done_nxt = 1'b1;
            ptr_nxt     = ptr_inc;
            sda_oe_nxt  = 1'b1;
            state_nxt   = WRITE_ACK;
          end
        end

        WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = WRITE;
          end
        end

        // bit_cnt counts bits already presented; the MSB goes out on entry.
        READ: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              ptr_nxt     = ptr_inc;
              bit_cnt_nxt = '0;
              state_nxt   = READ_ACK;
            end else begin
              tx_nxt      = {tx_shift[6:0], 1'b0};
              sda_oe_nxt  = ~tx_shift[6];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        READ_ACK: begin
          if (scl_rise) begin
            ack_nxt = sda_s2;
          end else if (scl_fall) begin
            if (!ack_bit) begin
              tx_nxt      = cur_byte;
              sda_oe_nxt  = ~cur_byte[7];
              bit_cnt_nxt = 4'd1;
              state_nxt   = READ;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WAIT_STOP;
            end
          end
        end

        WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
        end

        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: the bench plays the I2C master on a pulled-up bus.
module tb_i2c_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b1;
  logic        m_drv = 1'b0;
  wire         sda_bus;
  logic [31:0] slv_regs;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        addr_match;
  logic        busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   rx_cnt = 0;
  logic am_seen = 1'b0;

  pullup (sda_bus);
  assign sda_bus = m_drv ? 1'b0 : 1'bz;

  i2c_slave #(.SLV_ADDR(7'h5A), .NUM_REGS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .SCL        (scl),
    .SDA        (sda_bus),
    .slv_regs   (slv_regs),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .addr_match (addr_match),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count rx_done pulses and note any addr_match assertion.
  always @(posedge clk) begin
    if (rx_done) rx_cnt <= rx_cnt + 1;
    if (addr_match) am_seen <= 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting and ending with SCL low; s = SDA seen mid-high.
  task automatic m_bit(input logic b, output logic s);
    m_drv = ~b;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    s = sda_bus;
    wait_clk(8);
    scl = 1'b0;
    wait_clk(8);
  endtask

  task automatic m_start();
    m_drv = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(16);
    m_drv = 1'b1;
    wait_clk(16);
    scl = 1'b0;
    wait_clk(8);
  endtask

  task automatic m_stop();
    m_drv = 1'b1;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(16);
    m_drv = 1'b0;
    wait_clk(16);
  endtask

  task automatic m_write(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(nack, s);
  endtask

  task automatic test_reset();
    wait_clk(3);
    vectors++;
    if (slv_regs !== 32'h0 || rx_data !== 8'h00 || rx_done !== 1'b0 ||
        addr_match !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: regs=%h rx=%h done=%b am=%b busy=%b, need all 0",
               slv_regs, rx_data, rx_done, addr_match, busy);
    end
    vectors++;
    if (sda_bus !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sda: got %b need 1", sda_bus);
    end
    reset = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] d [3];
    d = '{8'hB4, 8'h11, 8'h22};
    rx_cnt = 0;
    m_start();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL write_busy: got %b need 1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      m_write(d[i], ack);
      vectors++;
      if (ack !== 1'b0) begin
        miscompares++;
        $display("FAIL write_ack%0d: got %b need 0", i, ack);
      end
      if (i == 0) begin
        vectors++;
        if (addr_match !== 1'b1) begin
          miscompares++;
          $display("FAIL write_addr_match: got %b need 1", addr_match);
        end
      end
    end
    m_stop();
    vectors++;
    if (slv_regs[15:0] !== 16'h2211) begin
      miscompares++;
      $display("FAIL write_regs: got %h need 2211", slv_regs[15:0]);
    end
    vectors++;
    if (rx_cnt !== 2) begin
      miscompares++;
      $display("FAIL write_rx_done_count: got %0d need 2", rx_cnt);
    end
    vectors++;
    if (rx_data !== 8'h22) begin
      miscompares++;
      $display("FAIL write_rx_data: got %h need 22", rx_data);
    end
    vectors++;
    if (busy !== 1'b0 || addr_match !== 1'b0) begin
      miscompares++;
      $display("FAIL write_after_stop: busy=%b am=%b need 0 0", busy, addr_match);
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    am_seen = 1'b0;
    m_start();
    m_write(8'hA0, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL mismatch_nack: got %b need 1", ack);
    end
    m_stop();
    vectors++;
    if (slv_regs !== 32'h0000_2211) begin
      miscompares++;
      $display("FAIL mismatch_regs: got %h need 00002211", slv_regs);
    end
    vectors++;
    if (am_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL mismatch_addr_match: got %b need 0", am_seen);
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] got;
    logic [7:0] pre [4];
    pre = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    m_start();
    m_write(8'hB4, ack);
    for (int i = 0; i < 4; i++) m_write(pre[i], ack);
    m_stop();
    vectors++;
    if (slv_regs !== 32'hD4C3_B2A1) begin
      miscompares++;
      $display("FAIL read_preload: got %h need D4C3B2A1", slv_regs);
    end
    m_start();
    m_write(8'hB5, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL read_addr_ack: got %b need 0", ack);
    end
    for (int i = 0; i < 4; i++) begin
      m_read(i == 3, got);
      vectors++;
      if (got !== pre[i]) begin
        miscompares++;
        $display("FAIL read_byte%0d: got %h need %h", i, got, pre[i]);
      end
    end
    // After the NACK the slave must keep the line released until STOP.
    m_read(1'b1, got);
    vectors++;
    if (got !== 8'hFF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL read_wait_stop: sda byte=%h busy=%b need FF 1", got, busy);
    end
    m_stop();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_after_stop: busy=%b need 0", busy);
    end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] got;
    m_start();
    m_write(8'hB4, ack);
    m_write(8'h55, ack);
    m_start();
    m_write(8'hB5, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rstart_addr_ack: got %b need 0", ack);
    end
    m_read(1'b1, got);
    m_stop();
    vectors++;
    if (got !== 8'h55) begin
      miscompares++;
      $display("FAIL rstart_read: got %h need 55", got);
    end
    vectors++;
    if (slv_regs !== 32'hD4C3_B255) begin
      miscompares++;
      $display("FAIL rstart_regs: got %h need D4C3B255", slv_regs);
    end
  endtask

  task automatic test_pointer_wrap();
    logic ack;
    m_start();
    m_write(8'hB4, ack);
    for (int i = 1; i <= 5; i++) m_write(8'(i), ack);
    m_stop();
    vectors++;
    if (slv_regs !== 32'h0403_0205) begin
      miscompares++;
      $display("FAIL wrap_regs: got %h need 04030205", slv_regs);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    m_start();
    m_write(8'hB5, ack);
    // reg0 = 05, so the first data bit driven is 0.
    vectors++;
    if (sda_bus !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_read_drive: got %b need 0", sda_bus);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (sda_bus !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_read_release: got %b need 1", sda_bus);
    end
    vectors++;
    if (slv_regs !== 32'h0 || rx_data !== 8'h00 || rx_done !== 1'b0 ||
        addr_match !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_read_outputs: regs=%h rx=%h done=%b am=%b busy=%b, need all 0",
               slv_regs, rx_data, rx_done, addr_match, busy);
    end
    wait_clk(3);
    reset = 1'b1;
    wait_clk(6);
    m_start();
    m_write(8'hB4, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_addr_ack: got %b need 0", ack);
    end
    m_write(8'h77, ack);
    m_stop();
    vectors++;
    if (ack !== 1'b0 || slv_regs !== 32'h0000_0077 || rx_data !== 8'h77) begin
      miscompares++;
      $display("FAIL post_reset_write: ack=%b regs=%h rx=%h need 0 00000077 77",
               ack, slv_regs, rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_pointer_wrap();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
